// File: rtl/uart_pkg.sv
// Shared UART constants: baud divisors, 8N1 frame shape and the transmitter FSM encoding.
package uart_pkg;

    localparam int CLK_50MHZ      = 50_000_000;
    localparam int CLK_DIV_115200 = 434;
    localparam int CLK_DIV_9600   = 5208;
    localparam int FRAME_BITS     = 10;
    localparam int DATA_BITS      = 8;
    localparam int BAUD_CNT_W     = 13;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Single-clock show-ahead FIFO; head is on rdata combinationally, pointers move one edge after wr/rd.
// Writes while full are dropped; reads while empty are ignored (full is judged before a same-cycle pop).
module tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/tx_serial_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; line falls two edges after a write into an idle block.
// No backpressure beyond tx_full: a write while full is dropped and flagged on tx_overflow.
module tx_serial_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       tx
);
    localparam logic [BAUD_CNT_W-1:0] DIV_LAST = BAUD_CNT_W'(CLK_DIV - 1);

    tx_state_e             state_q, state_d;
    logic [BAUD_CNT_W-1:0] baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  fifo_rd, bit_end;
    logic [7:0]            fifo_rdata;

    tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (tx_wr),
        .wdata (tx_data),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .full  (tx_full),
        .empty (tx_empty)
    );

    assign bit_end     = (baud_q == DIV_LAST);
    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_overflow = tx_wr & tx_full;
    assign tx          = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        fifo_rd = 1'b0;
        // Line is registered from the current state, so it trails the FSM by one cycle.
        unique case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase
        if (state_q != ST_IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (!tx_empty) begin
                    fifo_rd = 1'b1;
                    shift_d = fifo_rdata;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!tx_empty) begin
                        fifo_rd = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_tx_serial_fifo.sv
// Bench for tx_serial_fifo: a fast instance (CLK_DIV=4, depth 4) with a line decoder feeding a
// scoreboard, plus a 115200-baud instance checked for bit width, frame length and loopback.
module tb_tx_serial_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data_f, tx_data_s;
    logic       tx_wr_f, tx_wr_s;
    logic       full_f, empty_f, busy_f, ovf_f, tx_f;
    logic       full_s, empty_s, busy_s, ovf_s, tx_s;

    int         checks   = 0;
    int         failures = 0;
    int         rst_cnt  = 0;
    logic [7:0] exp_f[$];
    logic [7:0] exp_s[$];
    logic [7:0] bdat [6];

    always #5 clk = ~clk;

    tx_serial_fifo #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_fast (
        .clk(clk), .rst(rst), .tx_data(tx_data_f), .tx_wr(tx_wr_f),
        .tx_full(full_f), .tx_empty(empty_f), .tx_busy(busy_f),
        .tx_overflow(ovf_f), .tx(tx_f)
    );

    tx_serial_fifo #(.CLK_DIV(434), .FIFO_DEPTH(16)) u_slow (
        .clk(clk), .rst(rst), .tx_data(tx_data_s), .tx_wr(tx_wr_s),
        .tx_full(full_s), .tx_empty(empty_s), .tx_busy(busy_s),
        .tx_overflow(ovf_s), .tx(tx_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) if (rst) rst_cnt++;

    // Line decoder for the fast instance: finds each start bit and samples mid-bit.
    initial begin
        logic       prev;
        logic [7:0] b;
        logic       stopb;
        int         rc;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev && !tx_f) begin
                rc = rst_cnt;
                repeat (2) @(negedge clk);
                if (rc == rst_cnt) check("start_bit", tx_f, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx_f;
                end
                repeat (4) @(negedge clk);
                stopb = tx_f;
                if (rc == rst_cnt) begin
                    check("stop_bit", stopb, 1);
                    if (exp_f.size() == 0) check("unexpected_frame", b, 32'hFFFF_FFFF);
                    else                   check("rx_byte", b, exp_f.pop_front());
                end
            end
            prev = tx_f;
        end
    end

    task automatic wr1(input logic [7:0] d);
        @(negedge clk);
        tx_wr_f   = 1'b1;
        tx_data_f = d;
        @(negedge clk);
        tx_wr_f   = 1'b0;
    endtask

    // Writes bdat[0..n-1] on consecutive edges, then counts busy cycles until the line goes idle.
    task automatic burst(input int n, output int busy_cyc, output int ovf_cnt,
                         output int ovf_idx, output logic full_end);
        int g;
        busy_cyc = 0; ovf_cnt = 0; ovf_idx = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (busy_f) busy_cyc++;
            tx_wr_f   = 1'b1;
            tx_data_f = bdat[i];
            #1;
            if (ovf_f) begin ovf_cnt++; ovf_idx = i; end
        end
        @(negedge clk);
        tx_wr_f  = 1'b0;
        full_end = full_f;
        if (busy_f) busy_cyc++;
        g = 0;
        while (busy_f && g < 3000) begin
            @(negedge clk);
            if (busy_f) busy_cyc++;
            g++;
        end
        check("burst_idle", busy_f, 0);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_f.size() != 0 || busy_f) && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("drain_queue_empty", exp_f.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [9:0] frame;
        int         bc, oc, oi, fall, low, g;
        logic       fe, run_done, stopb;
        logic [7:0] b;

        rst = 1'b1; tx_wr_f = 1'b0; tx_wr_s = 1'b0; tx_data_f = '0; tx_data_s = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_tx", tx_f, 1);
            check("idle_busy", busy_f, 0);
            check("idle_empty", empty_f, 1);
            check("idle_full", full_f, 0);
            check("idle_ovf", ovf_f, 0);
        end
        check("idle_slow_tx", tx_s, 1);

        // Single byte: line shape and busy window.
        exp_f.push_back(8'h55);
        wr1(8'h55);
        check("w55_empty_after_wr", empty_f, 0);
        check("w55_tx_still_high", tx_f, 1);
        @(negedge clk);
        check("w55_busy_rise", busy_f, 1);
        check("w55_tx_one_edge", tx_f, 1);
        frame = {1'b1, 8'h55, 1'b0};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("w55_line", tx_f, frame[c / 4]);
            check("w55_busy", busy_f, (c < 39) ? 1 : 0);
        end
        check("w55_empty_end", empty_f, 1);
        repeat (5) @(negedge clk);

        // Three back-to-back frames.
        bdat[0] = 8'hA3; bdat[1] = 8'h0F; bdat[2] = 8'hFF;
        for (int i = 0; i < 3; i++) exp_f.push_back(bdat[i]);
        burst(3, bc, oc, oi, fe);
        check("b2b_busy_cycles", bc, 120);
        check("b2b_no_ovf", oc, 0);
        drain();

        // Depth-4 FIFO: first write is popped at once, next four fill it, the sixth is dropped.
        bdat[0] = 8'h10; bdat[1] = 8'h21; bdat[2] = 8'h32;
        bdat[3] = 8'h43; bdat[4] = 8'h54; bdat[5] = 8'h65;
        for (int i = 0; i < 5; i++) exp_f.push_back(bdat[i]);
        burst(6, bc, oc, oi, fe);
        check("ovf_full_after_fill", fe, 1);
        check("ovf_pulse_count", oc, 1);
        check("ovf_dropped_index", oi, 5);
        check("ovf_busy_cycles", bc, 200);
        drain();

        // Write landing on the STOP->START pop edge (0x11 popped at N+1, 0x22 at N+41).
        exp_f.push_back(8'h11); exp_f.push_back(8'h22); exp_f.push_back(8'h33);
        wr1(8'h11);
        wr1(8'h22);
        repeat (37) @(negedge clk);
        wr1(8'h33);
        check("pop_wr_busy", busy_f, 1);
        check("pop_wr_not_empty", empty_f, 0);
        drain();

        // Reset mid-DATA with two bytes still queued.
        wr1(8'h81);
        wr1(8'h99);
        wr1(8'hAA);
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy_f, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_tx", tx_f, 1);
        check("rst_busy", busy_f, 0);
        check("rst_empty", empty_f, 1);
        check("rst_full", full_f, 0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_line", tx_f, 1);
        exp_f.push_back(8'h42);
        wr1(8'h42);
        drain();

        // 115200-baud instance: start width, busy length and decoded byte.
        exp_s.push_back(8'h4B);
        @(negedge clk);
        tx_wr_s = 1'b1; tx_data_s = 8'h4B;
        @(negedge clk);
        tx_wr_s = 1'b0;
        bc = 0; fall = -1; low = 0; run_done = 1'b0; stopb = 1'b0; b = '0;
        for (g = 0; g < 4600; g++) begin
            if (busy_s) bc++;
            if (fall < 0 && !tx_s) fall = g;
            if (fall >= 0) begin
                int k;
                k = g - fall;
                if (!run_done) begin
                    if (!tx_s) low++;
                    else run_done = 1'b1;
                end
                if (k >= 651 && (k - 217) % 434 == 0) begin
                    if ((k - 217) / 434 <= 8) b[(k - 217) / 434 - 1] = tx_s;
                    else if ((k - 217) / 434 == 9) stopb = tx_s;
                end
            end
            @(negedge clk);
        end
        check("slow_fall_offset", fall, 2);
        check("slow_start_width", low, 434);
        check("slow_busy_len", bc, 4340);
        check("slow_stop_bit", stopb, 1);
        check("slow_loopback", b, exp_s.pop_front());
        check("slow_idle_after", busy_s, 0);

        check("scoreboard_empty", exp_f.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_serial_fifo.md
# tx_serial_fifo

UART transmitter, 8N1, the outbound counterpart of the system's serial receiver. The CPU/bus side pushes bytes into a small internal FIFO; the block serialises them onto the TX GPIO pin at a fixed baud derived from the 50 MHz system clock. Back-to-back bytes are sent with no idle gap between frames.

## Interface
- CLK_DIV, 434: clock cycles per bit. 434 gives ~115200 baud at 50 MHz; 5208 gives 9600. Legal range 2..8191 (13-bit counter).
- FIFO_DEPTH, 16: byte entries; power of two, 2..256.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, synchronous, active-high; clock clk.
- tx_data  in  8  byte to queue.
- tx_wr  in  1  write strobe; `tx_data` is queued on a clk edge where `tx_wr`=1 and `tx_full`=0.
- tx_full  out  1  FIFO holds FIFO_DEPTH bytes.
- tx_empty  out  1  FIFO holds no bytes.
- tx_busy  out  1  a frame is being shifted out (state ≠ IDLE).
- tx_overflow  out  1  one-cycle pulse when `tx_wr`=1 while `tx_full`=1; that byte is dropped.
- tx  out  1  serial line, idle MARK (1).

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `tx_full`=0, `tx_empty`=1, `tx_overflow`=0. FIFO pointers, count, bit counter and baud counter are all 0. State is IDLE.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for CLK_DIV cycles, then shift right. After bit index 7 completes, go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START. Otherwise go to IDLE.
- Bit order is LSB first. There is no parity and exactly one stop bit.
- `tx` is driven from a register (glitch-free pin).
- The baud counter counts 0..CLK_DIV−1 and wraps. A bit boundary occurs when count = CLK_DIV−1.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo depth. The count is log2(FIFO_DEPTH)+1 bits.
- Simultaneous write and pop:
  - When not full, both happen and the count is unchanged.
  - When full, the write is rejected (full is evaluated before the pop) and `tx_overflow` pulses.
  - When the FIFO is empty, a write and pop in the same cycle cannot occur, because a pop requires non-empty at the cycle start.
- Reset mid-frame: on the next edge, `tx`=1 and the frame is truncated. FIFO contents are discarded.

## Timing
- Write to empty FIFO in IDLE at edge N: `tx_empty`=0 after N. Pop and START entry at edge N+1. `tx` falls after edge N+2.
- Frame length is exactly 10·CLK_DIV cycles from `tx` fall to the end of the stop bit.
- `tx_busy` rises with START entry and falls on IDLE entry.
- Back-to-back: the next start bit begins the cycle immediately after the last stop-bit cycle. k queued bytes take 10·k·CLK_DIV cycles.
- `tx_full` and `tx_empty` update on the edge after the write or pop that changes the count.

## Structure
- Shared package `uart_pkg` holds:
  - baud constants: CLK_DIV_115200=434, CLK_DIV_9600=5208, CLK_50MHZ;
  - FSM state encoding (IDLE, START, DATA, STOP, 2-bit);
  - the 8N1 frame length (10).
- Sub-module `tx_fifo` is a synchronous single-clock FIFO.
  - Ports: clk, rst, wr, wdata, rd, rdata, full, empty.
  - rdata is valid combinationally at head (show-ahead).
- The FSM and baud counter live in the top.

## Test plan
- Reset, no writes, 100 cycles (CLK_DIV=4): `tx`=1, `tx_busy`=0, `tx_empty`=1, `tx_full`=0, `tx_overflow`=0 throughout.
- Write 0x55 (CLK_DIV=4):
  - `tx` falls 2 cycles after the write.
  - Line then holds 0,1,0,1,0,1,0,1,0,1 per 4-cycle bit.
  - `tx_busy` is high for 40 cycles, then IDLE.
- Write 0xA3, 0x0F, 0xFF in consecutive cycles:
  - Three frames with no idle gap, total 120 cycles at CLK_DIV=4.
  - The checker decodes bytes A3, 0F, FF in order.
- FIFO_DEPTH=4, write 6 bytes in consecutive cycles while the first frame is in progress:
  - First byte popped, next 4 stored, `tx_full`=1.
  - Last write gives one `tx_overflow` pulse and that byte is never transmitted.
  - Write exactly when the STOP→START pop occurs is accepted.
- Assert `rst` mid-DATA of 0x81 with 2 bytes still queued:
  - `tx`=1 the next cycle, `tx_empty`=1, `tx_busy`=0.
  - A subsequent write of 0x42 transmits correctly.
- CLK_DIV=434, 0x4B: start-bit width is 434 cycles and frame length is 4340 cycles. A loopback through the serial receiver returns 0x4B.
